comparador_serial: RTL

- Multi-cycle magnitude comparator for the processor datapath; next generation of the single-cycle equality block.
- Compares two WIDTH-bit operands CHUNK bits per clock, most significant chunk first, and stops early at the first differing chunk.
- Reports equal / greater / less with a start/busy/done handshake, so the control FSM can issue compares without a wide combinational path.

---
 rtl/comparador_serial_pkg.sv | 18 +
 rtl/comparador_serial_if.sv | 33 +++
 rtl/comparador_serial_cmp_chunk.sv | 12 +
 rtl/comparador_serial.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/comparador_serial_pkg.sv
// Shared types and sizing helpers for the chunk-serial magnitude comparator.
package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comparador_serial_if.sv
// Request/result bundle of comparador_serial; signed_mode exists only with SIGNED_CMP_EN.
interface comparador_serial_if #(
    parameter int WIDTH = 4
);
    logic               enable;
    logic [0:WIDTH-1]   A;
    logic [0:WIDTH-1]   B;
    logic               busy;
    logic               done;
    logic               ab_eq;
    logic               ab_gt;
    logic               ab_lt;
`ifdef SIGNED_CMP_EN
    logic               signed_mode;
`endif

    modport master (
`ifdef SIGNED_CMP_EN
        output signed_mode,
`endif
        output enable, A, B,
        input  busy, done, ab_eq, ab_gt, ab_lt
    );

    modport slave (
`ifdef SIGNED_CMP_EN
        input  signed_mode,
`endif
        input  enable, A, B,
        output busy, done, ab_eq, ab_gt, ab_lt
    );

endinterface

// File: rtl/comparador_serial_cmp_chunk.sv
// Unsigned compare of one CHUNK-bit slice.
module cmp_chunk #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt
);
    assign gt = (a > b);
    assign lt = (a < b);
endmodule

// File: rtl/comparador_serial.sv
// Multi-cycle comparator, most significant chunk first with early exit.
// SIGNED_CMP_EN adds a latched two's-complement mode (sign bit is bit 0).
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CHUNK = 1
) (
    input  logic              clk,
    input  logic              rst,
    comparador_serial_if.slave bus
);
    localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
    localparam int PW     = NCHUNK * CHUNK;
    localparam int CNTW   = cnt_width(NCHUNK);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NCHUNK - 1);

    state_t           r_state, w_state_nx;
    logic [CNTW-1:0]  r_cnt, w_cnt_nx;
    logic [0:WIDTH-1] r_a, r_b, w_a_nx, w_b_nx;
    logic             r_eq, r_gt, r_lt, w_eq_nx, w_gt_nx, w_lt_nx;
    logic             r_busy, r_done, w_busy_nx, w_done_nx;
    logic [0:WIDTH-1] w_op_a, w_op_b;
    logic [0:PW-1]    w_pad_a, w_pad_b;
    logic [CHUNK-1:0] w_chunks_a [NCHUNK];
    logic [CHUNK-1:0] w_chunks_b [NCHUNK];
    logic             w_gt, w_lt;

`ifdef SIGNED_CMP_EN
    logic             r_signed, w_signed_nx;

    // Operand view after optional sign-bit flip
    always_comb begin
        w_op_a    = r_a;
        w_op_b    = r_b;
        w_op_a[0] = r_a[0] ^ r_signed;
        w_op_b[0] = r_b[0] ^ r_signed;
    end
`else
    assign w_op_a = r_a;
    assign w_op_b = r_b;
`endif

    // Zero-extension lands on index 0 side, so only chunk 0 carries pad bits
    assign w_pad_a = PW'(w_op_a);
    assign w_pad_b = PW'(w_op_b);

    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        assign w_chunks_a[g] = w_pad_a[g*CHUNK +: CHUNK];
        assign w_chunks_b[g] = w_pad_b[g*CHUNK +: CHUNK];
    end

    cmp_chunk #(.CHUNK(CHUNK)) u_cmp (
        .a  (w_chunks_a[r_cnt]),
        .b  (w_chunks_b[r_cnt]),
        .gt (w_gt),
        .lt (w_lt)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_a_nx      = r_a;
        w_b_nx      = r_b;
        w_eq_nx     = r_eq;
        w_gt_nx     = r_gt;
        w_lt_nx     = r_lt;
`ifdef SIGNED_CMP_EN
        w_signed_nx = r_signed;
`endif
        case (r_state)
            IDLE: begin
                if (bus.enable) begin
                    w_a_nx      = bus.A;
                    w_b_nx      = bus.B;
`ifdef SIGNED_CMP_EN
                    w_signed_nx = bus.signed_mode;
`endif
                    w_eq_nx     = 1'b0;
                    w_gt_nx     = 1'b0;
                    w_lt_nx     = 1'b0;
                    w_cnt_nx    = '0;
                    w_state_nx  = RUN;
                end else begin
                    w_state_nx  = IDLE;
                end
            end
            RUN: begin
                if (w_gt) begin
                    w_gt_nx    = 1'b1;
                    w_state_nx = DONE;
                end else if (w_lt) begin
                    w_lt_nx    = 1'b1;
                    w_state_nx = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_eq_nx    = 1'b1;
                    w_state_nx = DONE;
                end else begin
                    w_cnt_nx   = r_cnt + CNTW'(1);
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        w_busy_nx = (w_state_nx != IDLE);
        w_done_nx = (w_state_nx == DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SIGNED_CMP_EN
            r_signed <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_a      <= w_a_nx;
            r_b      <= w_b_nx;
            r_eq     <= w_eq_nx;
            r_gt     <= w_gt_nx;
            r_lt     <= w_lt_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
`ifdef SIGNED_CMP_EN
            r_signed <= w_signed_nx;
`endif
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.ab_eq = r_eq;
    assign bus.ab_gt = r_gt;
    assign bus.ab_lt = r_lt;

endmodule
